// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified-memory port arbiter: response owner tags,
// DMType encodings and arbiter FSM states.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_DM   = 2'd2
    } owner_t;

    typedef struct packed {
        owner_t owner;
        logic   kill;
    } tag_t;

    localparam tag_t TAG_EMPTY = '{owner: TAG_NONE, kill: 1'b0};

    localparam logic [2:0] DM_WORD   = 3'd0;
    localparam logic [2:0] DM_HALF   = 3'd1;
    localparam logic [2:0] DM_HALF_U = 3'd2;
    localparam logic [2:0] DM_BYTE   = 3'd3;
    localparam logic [2:0] DM_BYTE_U = 3'd4;

    typedef enum logic {
        NORMAL   = 1'b0,
        FORCE_IF = 1'b1
    } arb_state_t;

    // A redirect poisons any fetch tag it touches; data tags pass untouched.
    function automatic tag_t mark_kill(tag_t t, logic flush);
        tag_t r;
        r      = t;
        r.kill = t.kill | (flush && (t.owner == TAG_IF));
        return r;
    endfunction

endpackage

// File: rtl/resp_tag_pipe.sv
// MEM_LAT-deep shift register of {owner, kill} tags that lines up with the
// memory's fixed read latency; flush marks in-flight fetch tags as killed.
module resp_tag_pipe
    import cpu_mem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [MEM_LAT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                stage[i] <= TAG_EMPTY;
            end
        end else begin
            stage[0] <= mark_kill(tag_in, flush);
            for (int i = 1; i < MEM_LAT; i++) begin
                stage[i] <= mark_kill(stage[i-1], flush);
            end
        end
    end

    assign tag_out = stage[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory between fetch and MEM-stage data ports:
// one combinational grant per cycle, read responses routed back by tag.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_type,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              flush,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              m_req,
    output logic              m_we,
    output logic [2:0]        m_type,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;
    tag_t             tag_in;
    tag_t             tag_out;

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst) begin
            if (state == FORCE_IF) begin
                if_gnt = if_req;
                dm_gnt = dm_req & ~if_req;
            end else begin
                dm_gnt = dm_req;
                if_gnt = if_req & ~dm_req;
            end
        end
    end

    always_comb begin
        starve_nxt = '0;
        if (if_req && !if_gnt) begin
            starve_nxt = (starve_cnt == CNT_W'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
        end
    end

    // Entering FORCE_IF on the edge the counter saturates means IF wins the
    // very cycle in which starve_cnt reads STARVE_MAX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            case (state)
                NORMAL:   if (starve_nxt == CNT_W'(STARVE_MAX)) state <= FORCE_IF;
                FORCE_IF: if (if_gnt || !if_req) state <= NORMAL;
                default:  state <= NORMAL;
            endcase
        end
    end

    assign stall_if  = rst & if_req & ~if_gnt;
    assign stall_mem = rst & dm_req & ~dm_gnt;

    assign m_req   = if_gnt | dm_gnt;
    assign m_we    = dm_gnt & dm_we;
    assign m_type  = dm_gnt ? dm_type : DM_WORD;
    assign m_addr  = dm_gnt ? dm_addr : if_addr;
    assign m_wdata = dm_wdata;

    always_comb begin
        tag_in = TAG_EMPTY;
        if (if_gnt) begin
            tag_in.owner = TAG_IF;
        end else if (dm_gnt && !dm_we) begin
            tag_in.owner = TAG_DM;
        end
    end

    resp_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // A redirect in the return cycle also drops the fetch being delivered.
    assign if_rvalid = rst & (tag_out.owner == TAG_IF) & ~tag_out.kill & ~flush;
    assign dm_rvalid = rst & (tag_out.owner == TAG_DM);
    assign if_rdata  = m_rdata;
    assign dm_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a MEM_LAT=1 and a MEM_LAT=2 arbiter with identical requests and
// checks both against a cycle-history reference model.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    localparam int STARVE_MAX = 4;
    localparam int N          = 2048;

    logic        clk;
    logic        rst;
    logic        if_req, dm_req, dm_we, flush;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [2:0]  dm_type;

    logic        if_gnt_w [2], if_rvalid_w [2], dm_gnt_w [2], dm_rvalid_w [2];
    logic        stall_if_w [2], stall_mem_w [2], m_req_w [2], m_we_w [2];
    logic [2:0]  m_type_w [2];
    logic [31:0] if_rdata_w [2], dm_rdata_w [2], m_addr_w [2], m_wdata_w [2], m_rdata_w [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1), .STARVE_MAX(STARVE_MAX)
        ) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[g]),
            .if_rvalid(if_rvalid_w[g]), .if_rdata(if_rdata_w[g]),
            .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr),
            .dm_wdata(dm_wdata), .dm_gnt(dm_gnt_w[g]), .dm_rvalid(dm_rvalid_w[g]),
            .dm_rdata(dm_rdata_w[g]), .flush(flush),
            .stall_if(stall_if_w[g]), .stall_mem(stall_mem_w[g]),
            .m_req(m_req_w[g]), .m_we(m_we_w[g]), .m_type(m_type_w[g]),
            .m_addr(m_addr_w[g]), .m_wdata(m_wdata_w[g]), .m_rdata(m_rdata_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int run    = 0;    // consecutive cycles IF has asked and been refused

    // Per-cycle history: owner 0=none 1=fetch 2=load, plus address/flush/reset.
    logic [1:0]  h_own [N];
    logic [31:0] h_addr [N];
    logic        h_flush [N];
    logic        h_rst [N];

    logic        mdl_if_gnt, mdl_dm_gnt;
    logic        o_if_gnt, o_dm_gnt, o_stall_if, o_stall_mem, o_m_req, o_m_we;
    logic [31:0] o_m_addr, o_m_wdata, o_if_rdata;
    logic        o_if_rvalid [2], o_dm_rvalid [2];

    function automatic logic [31:0] fdata(logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
    endfunction

    // Who should see read data this cycle on the port with latency lat.
    function automatic logic [1:0] ret_owner(int lat);
        int s;
        s = cyc - lat;
        if (s < 0 || !rst || h_own[s] == 2'd0) return 2'd0;
        for (int k = s + 1; k < cyc; k++) if (!h_rst[k]) return 2'd0;
        if (h_own[s] == 2'd1) begin
            for (int k = s; k < cyc; k++) if (h_flush[k]) return 2'd0;
            if (flush) return 2'd0;
        end
        return h_own[s];
    endfunction

    task automatic chk(string tag, int g, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s dut%0d cyc=%0d got=%h want=%h", tag, g, cyc, obs, exp);
    endtask

    task automatic step();
        logic       eg_if, eg_dm;
        logic [1:0] eo;
        int         src;
        for (int g = 0; g < 2; g++) begin
            src = cyc - (g + 1);
            m_rdata_w[g] = (src >= 0 && h_own[src] != 2'd0) ? fdata(h_addr[src]) : $urandom;
        end
        eg_if = 1'b0;
        eg_dm = 1'b0;
        if (rst) begin
            if (if_req && (!dm_req || run >= STARVE_MAX)) eg_if = 1'b1;
            else if (dm_req) eg_dm = 1'b1;
        end
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("if_gnt", g, 32'(if_gnt_w[g]), 32'(eg_if));
            chk("dm_gnt", g, 32'(dm_gnt_w[g]), 32'(eg_dm));
            chk("stall_if", g, 32'(stall_if_w[g]), 32'(rst & if_req & ~eg_if));
            chk("stall_mem", g, 32'(stall_mem_w[g]), 32'(rst & dm_req & ~eg_dm));
            chk("m_req", g, 32'(m_req_w[g]), 32'(eg_if | eg_dm));
            chk("m_we", g, 32'(m_we_w[g]), 32'(eg_dm & dm_we));
            if (eg_if || eg_dm) begin
                chk("m_addr", g, m_addr_w[g], eg_dm ? dm_addr : if_addr);
                chk("m_type", g, 32'(m_type_w[g]), 32'(eg_dm ? dm_type : DM_WORD));
            end
            if (eg_dm && dm_we) chk("m_wdata", g, m_wdata_w[g], dm_wdata);
            eo = ret_owner(g + 1);
            chk("if_rvalid", g, 32'(if_rvalid_w[g]), 32'(eo == 2'd1));
            chk("dm_rvalid", g, 32'(dm_rvalid_w[g]), 32'(eo == 2'd2));
            if (eo == 2'd1) chk("if_rdata", g, if_rdata_w[g], fdata(h_addr[cyc-g-1]));
            if (eo == 2'd2) chk("dm_rdata", g, dm_rdata_w[g], fdata(h_addr[cyc-g-1]));
            o_if_rvalid[g] = if_rvalid_w[g];
            o_dm_rvalid[g] = dm_rvalid_w[g];
        end
        o_if_gnt    = if_gnt_w[0];
        o_dm_gnt    = dm_gnt_w[0];
        o_stall_if  = stall_if_w[0];
        o_stall_mem = stall_mem_w[0];
        o_m_req     = m_req_w[0];
        o_m_we      = m_we_w[0];
        o_m_addr    = m_addr_w[0];
        o_m_wdata   = m_wdata_w[0];
        o_if_rdata  = if_rdata_w[0];
        h_own[cyc]   = eg_if ? 2'd1 : ((eg_dm && !dm_we) ? 2'd2 : 2'd0);
        h_addr[cyc]  = eg_if ? if_addr : dm_addr;
        h_flush[cyc] = flush;
        h_rst[cyc]   = rst;
        if (!rst || !if_req || eg_if) run = 0;
        else if (run < STARVE_MAX) run = run + 1;
        mdl_if_gnt = eg_if;
        mdl_dm_gnt = eg_dm;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; flush = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_type = DM_WORD;
        mdl_if_gnt = 1'b0; mdl_dm_gnt = 1'b0;
        m_rdata_w[0] = '0; m_rdata_w[1] = '0;
        repeat (3) step();

        // First fetch after reset returns the NOP at address 0.
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h0;
        step();
        chk("t1_if_gnt", 0, 32'(o_if_gnt), 32'd1);
        chk("t1_m_addr", 0, o_m_addr, 32'h0);
        if_req = 1'b0;
        step();
        chk("t1_if_rvalid", 0, 32'(o_if_rvalid[0]), 32'd1);
        chk("t1_if_rdata", 0, o_if_rdata, 32'h0000_0013);

        // Data beats fetch; fetch goes once the load is gone.
        if_req = 1'b1; if_addr = 32'h4; dm_req = 1'b1; dm_addr = 32'h100;
        step();
        chk("t2_dm_gnt", 0, 32'(o_dm_gnt), 32'd1);
        chk("t2_if_gnt", 0, 32'(o_if_gnt), 32'd0);
        chk("t2_stall_if", 0, 32'(o_stall_if), 32'd1);
        dm_req = 1'b0;
        step();
        chk("t2_dm_rvalid", 0, 32'(o_dm_rvalid[0]), 32'd1);
        chk("t2_if_gnt_late", 0, 32'(o_if_gnt), 32'd1);
        if_req = 1'b0;
        step();

        // Anti-starvation: IF forced through on the fifth contested cycle.
        if_req = 1'b1; if_addr = 32'h8; dm_req = 1'b1; dm_addr = 32'h104;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t3_if_gnt", 0, 32'(o_if_gnt), 32'(i == 4));
            chk("t3_stall_mem", 0, 32'(o_stall_mem), 32'(i == 4));
        end
        if_req = 1'b0; dm_req = 1'b0;
        step();

        // Store produces no response.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        step();
        chk("t4_m_we", 0, 32'(o_m_we), 32'd1);
        chk("t4_m_wdata", 0, o_m_wdata, 32'hDEAD_BEEF);
        dm_req = 1'b0; dm_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_no_rvalid0", 0, 32'(o_dm_rvalid[0]), 32'd0);
            chk("t4_no_rvalid1", 1, 32'(o_dm_rvalid[1]), 32'd0);
        end

        // Flush kills the fetch but not the load issued alongside it.
        if_req = 1'b1; if_addr = 32'h8;
        step();
        if_req = 1'b0; flush = 1'b1; dm_req = 1'b1; dm_addr = 32'h300;
        step();
        chk("t5_if_rvalid0", 0, 32'(o_if_rvalid[0]), 32'd0);
        flush = 1'b0; dm_req = 1'b0;
        step();
        chk("t5_if_rvalid1", 1, 32'(o_if_rvalid[1]), 32'd0);
        step();
        chk("t5_dm_rvalid1", 1, 32'(o_dm_rvalid[1]), 32'd1);

        // Reset with reads in flight, then confirm a clean restart.
        dm_req = 1'b1; dm_addr = 32'h400;
        step();
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'hC;
        step();
        rst = 1'b0; if_req = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_m_req", 0, 32'(o_m_req), 32'd0);
            chk("t6_rvalid1", 1, 32'(o_if_rvalid[1] | o_dm_rvalid[1]), 32'd0);
        end
        if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_addr = 32'h500;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_starve_restart", 0, 32'(o_if_gnt), 32'(i == 4));
        end
        if_req = 1'b0; dm_req = 1'b0;
        step();

        // Random traffic; a refused request keeps its payload until granted.
        for (int i = 0; i < 400; i++) begin
            if (!(if_req && !mdl_if_gnt)) begin
                if_req  = ($urandom_range(0, 99) < 60);
                if_addr = 32'($urandom_range(0, 1023)) << 2;
            end
            if (!(dm_req && !mdl_dm_gnt)) begin
                dm_req   = ($urandom_range(0, 99) < 50);
                dm_we    = ($urandom_range(0, 99) < 30);
                dm_type  = 3'($urandom_range(0, 4));
                dm_addr  = 32'($urandom_range(0, 4095));
                dm_wdata = $urandom;
            end
            flush = ($urandom_range(0, 99) < 10);
            rst   = ($urandom_range(0, 99) >= 2);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
